// File: rtl/cpu_mem_pkg.sv
// Shared widths, FSM encoding and owner constants for the memory port arbiter.
package cpu_mem_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    // Returned to the requester in place of real data when the memory hangs.
    localparam logic [DATA_W-1:0] TIMEOUT_DATA = 16'hFFFF;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, memory and status signals around the memory port arbiter.
interface mem_port_arbiter_if;
    import cpu_mem_pkg::*;

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ack;

    logic              d_req;
    logic              d_rwn;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;

    logic              mem_start;
    logic              mem_rwn;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    logic              busy;
    logic              owner;
    logic              timeout_err;

    // master is the arbiter itself; slave is everything around it.
    modport master (
        input  i_req, i_addr, d_req, d_rwn, d_addr, d_wdata, mem_rdata, mem_ready,
        output i_rdata, i_ack, d_rdata, d_ack, mem_start, mem_rwn, mem_addr,
               mem_wdata, busy, owner, timeout_err
    );

    modport slave (
        output i_req, i_addr, d_req, d_rwn, d_addr, d_wdata, mem_rdata, mem_ready,
        input  i_rdata, i_ack, d_rdata, d_ack, mem_start, mem_rwn, mem_addr,
               mem_wdata, busy, owner, timeout_err
    );

endinterface

// File: rtl/rr_pick2.sv
// Two-way grant picker: round-robin on ties when enabled, otherwise D wins ties.
module rr_pick2
    import cpu_mem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    input  logic       rr_enable,
    output logic       grant,
    output logic       valid
);

    // req[0] is the fetch side, req[1] the data side.
    always_comb begin
        valid = |req;
        grant = OWN_I;
        if (req == 2'b11) begin
            grant = rr_enable ? ~last_owner : OWN_D;
        end else if (req[1]) begin
            grant = OWN_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one multi-cycle memory between fetch and data requesters, with a hung-memory watchdog.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter bit RR_ENABLE      = 1'b1,
    parameter int TIMEOUT_CYCLES = 8
)
(
    input  logic           clk,
    input  logic           reset,
    mem_port_arbiter_if.master bus
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t            state;
    state_t            state_next;
    logic              grant;
    logic              grant_valid;
    logic              take_grant;
    logic              capture;
    logic              expire;
    logic              wd_last;
    logic [WD_W-1:0]   wd_cnt;
    logic              owner_q;
    logic              last_owner;
    logic              rwn_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] i_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              timeout_q;

    rr_pick2 u_pick (
        .req        ({bus.d_req, bus.i_req}),
        .last_owner (last_owner),
        .rr_enable  (RR_ENABLE),
        .grant      (grant),
        .valid      (grant_valid)
    );

    assign wd_last = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        take_grant = 1'b0;
        capture    = 1'b0;
        expire     = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid && bus.mem_ready) begin
                    take_grant = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (bus.mem_ready) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end else if (wd_last) begin
                    expire     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // last_owner resets to D so that the fetch side wins the very first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q    <= OWN_I;
            last_owner <= OWN_D;
            rwn_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
            timeout_q  <= 1'b0;
            wd_cnt     <= '0;
        end else begin
            if (take_grant) begin
                owner_q <= grant;
                rwn_q   <= (grant == OWN_D) ? bus.d_rwn : 1'b1;
                addr_q  <= (grant == OWN_D) ? bus.d_addr : bus.i_addr;
                wdata_q <= (grant == OWN_D) ? bus.d_wdata : '0;
            end
            if (state == ISSUE) begin
                wd_cnt <= '0;
            end else if (state == WAIT && !bus.mem_ready) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (capture && rwn_q) begin
                if (owner_q == OWN_D) d_rdata_q <= bus.mem_rdata;
                else                  i_rdata_q <= bus.mem_rdata;
            end
            if (expire) begin
                timeout_q <= 1'b1;
                if (rwn_q) begin
                    if (owner_q == OWN_D) d_rdata_q <= TIMEOUT_DATA;
                    else                  i_rdata_q <= TIMEOUT_DATA;
                end
            end
            if (state == DONE) begin
                last_owner <= owner_q;
            end
        end
    end

    assign bus.mem_start   = (state == ISSUE);
    assign bus.busy        = (state != IDLE);
    assign bus.i_ack       = (state == DONE) && (owner_q == OWN_I);
    assign bus.d_ack       = (state == DONE) && (owner_q == OWN_D);
    assign bus.owner       = owner_q;
    assign bus.mem_rwn     = rwn_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.i_rdata     = i_rdata_q;
    assign bus.d_rdata     = d_rdata_q;
    assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a round-robin and a fixed-priority instance, each with a memory model.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic reset;
    logic hang;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if bus_rr ();
    mem_port_arbiter_if bus_fp ();

    mem_port_arbiter #(.RR_ENABLE(1'b1), .TIMEOUT_CYCLES(8)) dut_rr (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_rr)
    );

    mem_port_arbiter #(.RR_ENABLE(1'b0), .TIMEOUT_CYCLES(8)) dut_fp (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_fp)
    );

    // Memory model: ready drops after start and returns after 1 + addr[1:0] cycles.
    logic [15:0] mem_a [256];
    logic        rdy_a;
    logic [2:0]  cnt_a;
    logic [15:0] rd_a;
    logic [15:0] mem_b [256];
    logic        rdy_b;
    logic [2:0]  cnt_b;
    logic [15:0] rd_b;

    assign bus_rr.mem_ready = rdy_a;
    assign bus_rr.mem_rdata = rd_a;
    assign bus_fp.mem_ready = rdy_b;
    assign bus_fp.mem_rdata = rd_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            rdy_a <= 1'b1; cnt_a <= '0; rd_a <= '0;
            mem_a[0] <= 16'hA140; mem_a[3] <= 16'h3C33; mem_a[4] <= 16'h0B04;
        end else if (rdy_a) begin
            if (bus_rr.mem_start) begin
                rdy_a <= 1'b0;
                cnt_a <= {1'b0, bus_rr.mem_addr[1:0]};
                if (bus_rr.mem_rwn) rd_a <= mem_a[bus_rr.mem_addr];
                else                mem_a[bus_rr.mem_addr] <= bus_rr.mem_wdata;
            end
        end else if (!hang) begin
            if (cnt_a == 3'd0) rdy_a <= 1'b1;
            else               cnt_a <= cnt_a - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdy_b <= 1'b1; cnt_b <= '0; rd_b <= '0;
            mem_b[0] <= 16'hA140; mem_b[3] <= 16'h3C33; mem_b[4] <= 16'h0B04;
        end else if (rdy_b) begin
            if (bus_fp.mem_start) begin
                rdy_b <= 1'b0;
                cnt_b <= {1'b0, bus_fp.mem_addr[1:0]};
                if (bus_fp.mem_rwn) rd_b <= mem_b[bus_fp.mem_addr];
                else                mem_b[bus_fp.mem_addr] <= bus_fp.mem_wdata;
            end
        end else begin
            if (cnt_b == 3'd0) rdy_b <= 1'b1;
            else               cnt_b <= cnt_b - 3'd1;
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Runs one transaction on the round-robin instance; cycle 0 is the IDLE cycle that sees the request.
    task automatic do_txn(input bit is_d, input logic rwn, input logic [7:0] addr,
                          input logic [15:0] wdata, output int start_cyc, output int ack_cyc);
        start_cyc = -1;
        ack_cyc   = -1;
        if (is_d) begin
            bus_rr.d_req = 1'b1; bus_rr.d_rwn = rwn; bus_rr.d_addr = addr; bus_rr.d_wdata = wdata;
        end else begin
            bus_rr.i_req = 1'b1; bus_rr.i_addr = addr;
        end
        for (int k = 1; k <= 30 && ack_cyc < 0; k++) begin
            step();
            if (bus_rr.mem_start && start_cyc < 0) start_cyc = k;
            if (is_d ? bus_rr.d_ack : bus_rr.i_ack) ack_cyc = k;
        end
        bus_rr.i_req = 1'b0;
        bus_rr.d_req = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_checks++;
        if ({bus_rr.busy, bus_rr.owner, bus_rr.i_ack, bus_rr.d_ack, bus_rr.mem_start,
             bus_rr.mem_rwn, bus_rr.timeout_err} !== 7'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_flags: got %b expected 0000000",
                     {bus_rr.busy, bus_rr.owner, bus_rr.i_ack, bus_rr.d_ack, bus_rr.mem_start,
                      bus_rr.mem_rwn, bus_rr.timeout_err});
        end
        n_checks++;
        if ({bus_rr.i_rdata, bus_rr.d_rdata, bus_rr.mem_addr, bus_rr.mem_wdata} !== 56'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_data: got %h expected 0",
                     {bus_rr.i_rdata, bus_rr.d_rdata, bus_rr.mem_addr, bus_rr.mem_wdata});
        end
        reset = 1'b0;
    endtask

    task automatic test_fetch();
        int s, a;
        do_txn(1'b0, 1'b1, 8'd0, 16'h0, s, a);
        n_checks++;
        if (s !== 1) begin n_fail++; $display("[TB] FAIL fetch_start_cycle: got %0d expected 1", s); end
        n_checks++;
        if (a !== 4) begin n_fail++; $display("[TB] FAIL fetch_ack_cycle: got %0d expected 4", a); end
        n_checks++;
        if (bus_rr.i_rdata !== 16'hA140) begin
            n_fail++; $display("[TB] FAIL fetch_rdata: got %h expected a140", bus_rr.i_rdata);
        end
    endtask

    task automatic test_write_read();
        int s, a;
        do_txn(1'b1, 1'b0, 8'd15, 16'h1234, s, a);
        n_checks++;
        if (a !== 7) begin n_fail++; $display("[TB] FAIL write_ack_cycle: got %0d expected 7", a); end
        n_checks++;
        if (bus_rr.d_rdata !== 16'h0000) begin
            n_fail++; $display("[TB] FAIL write_keeps_rdata: got %h expected 0000", bus_rr.d_rdata);
        end
        do_txn(1'b1, 1'b1, 8'd15, 16'h0, s, a);
        n_checks++;
        if (a !== 7) begin n_fail++; $display("[TB] FAIL read_ack_cycle: got %0d expected 7", a); end
        n_checks++;
        if (bus_rr.d_rdata !== 16'h1234) begin
            n_fail++; $display("[TB] FAIL read_rdata: got %h expected 1234", bus_rr.d_rdata);
        end
        n_checks++;
        if (bus_rr.i_rdata !== 16'hA140) begin
            n_fail++; $display("[TB] FAIL read_i_rdata_held: got %h expected a140", bus_rr.i_rdata);
        end
    endtask

    task automatic test_round_robin();
        int  cyc [4];
        bit  who [4];
        int  n_acks = 0;
        int  overlap = 0;
        int  exp_cyc [4] = '{4, 9, 14, 19};
        bit  exp_who [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        bus_rr.i_req = 1'b1; bus_rr.i_addr = 8'd0;
        bus_rr.d_req = 1'b1; bus_rr.d_rwn = 1'b1; bus_rr.d_addr = 8'd4;
        for (int k = 1; k <= 19; k++) begin
            step();
            if (bus_rr.i_ack && bus_rr.d_ack) overlap++;
            if ((bus_rr.i_ack || bus_rr.d_ack) && n_acks < 4) begin
                cyc[n_acks] = k; who[n_acks] = bus_rr.d_ack; n_acks++;
            end
        end
        bus_rr.i_req = 1'b0;
        bus_rr.d_req = 1'b0;
        step();
        n_checks++;
        if (n_acks !== 4) begin n_fail++; $display("[TB] FAIL rr_ack_count: got %0d expected 4", n_acks); end
        for (int j = 0; j < n_acks; j++) begin
            n_checks++;
            if (who[j] !== exp_who[j] || cyc[j] !== exp_cyc[j]) begin
                n_fail++;
                $display("[TB] FAIL rr_ack%0d: got owner %0d cycle %0d expected owner %0d cycle %0d",
                         j, who[j], cyc[j], exp_who[j], exp_cyc[j]);
            end
        end
        n_checks++;
        if (overlap !== 0) begin n_fail++; $display("[TB] FAIL rr_overlap: got %0d expected 0", overlap); end
        n_checks++;
        if (bus_rr.d_rdata !== 16'h0B04) begin
            n_fail++; $display("[TB] FAIL rr_d_rdata: got %h expected 0b04", bus_rr.d_rdata);
        end
    endtask

    task automatic test_fixed_priority();
        int  cyc [4];
        bit  who [4];
        int  n_acks = 0;
        int  exp_cyc [4] = '{4, 9, 14, 19};
        bit  exp_who [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        bus_fp.i_req = 1'b1; bus_fp.i_addr = 8'd0;
        bus_fp.d_req = 1'b1; bus_fp.d_rwn = 1'b1; bus_fp.d_addr = 8'd4;
        for (int k = 1; k <= 19; k++) begin
            step();
            if ((bus_fp.i_ack || bus_fp.d_ack) && n_acks < 4) begin
                cyc[n_acks] = k; who[n_acks] = bus_fp.d_ack; n_acks++;
            end
            if (k == 14) bus_fp.d_req = 1'b0;
        end
        bus_fp.i_req = 1'b0;
        step();
        n_checks++;
        if (n_acks !== 4) begin n_fail++; $display("[TB] FAIL fp_ack_count: got %0d expected 4", n_acks); end
        for (int j = 0; j < n_acks; j++) begin
            n_checks++;
            if (who[j] !== exp_who[j] || cyc[j] !== exp_cyc[j]) begin
                n_fail++;
                $display("[TB] FAIL fp_ack%0d: got owner %0d cycle %0d expected owner %0d cycle %0d",
                         j, who[j], cyc[j], exp_who[j], exp_cyc[j]);
            end
        end
        n_checks++;
        if (bus_fp.i_rdata !== 16'hA140 || bus_fp.d_rdata !== 16'h0B04) begin
            n_fail++;
            $display("[TB] FAIL fp_rdata: got %h/%h expected a140/0b04", bus_fp.i_rdata, bus_fp.d_rdata);
        end
    endtask

    task automatic test_timeout();
        int s, a;
        hang = 1'b1;
        do_txn(1'b1, 1'b1, 8'd0, 16'h0, s, a);
        n_checks++;
        if (s !== 1 || a !== 10) begin
            n_fail++; $display("[TB] FAIL timeout_cycles: got start %0d ack %0d expected 1 10", s, a);
        end
        n_checks++;
        if (bus_rr.d_rdata !== 16'hFFFF) begin
            n_fail++; $display("[TB] FAIL timeout_rdata: got %h expected ffff", bus_rr.d_rdata);
        end
        n_checks++;
        if (bus_rr.timeout_err !== 1'b1) begin
            n_fail++; $display("[TB] FAIL timeout_flag: got %b expected 1", bus_rr.timeout_err);
        end
        hang = 1'b0;
        step();
        do_txn(1'b0, 1'b1, 8'd0, 16'h0, s, a);
        n_checks++;
        if (a !== 4 || bus_rr.i_rdata !== 16'hA140) begin
            n_fail++;
            $display("[TB] FAIL timeout_recover: got ack %0d data %h expected 4 a140", a, bus_rr.i_rdata);
        end
        n_checks++;
        if (bus_rr.timeout_err !== 1'b1) begin
            n_fail++; $display("[TB] FAIL timeout_sticky: got %b expected 1", bus_rr.timeout_err);
        end
    endtask

    task automatic test_reset_mid_txn();
        int s, a;
        int acks = 0;
        bus_rr.i_req = 1'b1; bus_rr.i_addr = 8'd3;
        for (int k = 1; k <= 3; k++) begin
            step();
            if (bus_rr.i_ack) acks++;
        end
        reset = 1'b1;
        bus_rr.i_req = 1'b0;
        step();
        if (bus_rr.i_ack) acks++;
        n_checks++;
        if (acks !== 0) begin n_fail++; $display("[TB] FAIL midreset_no_ack: got %0d expected 0", acks); end
        n_checks++;
        if ({bus_rr.busy, bus_rr.owner, bus_rr.mem_start, bus_rr.mem_rwn, bus_rr.timeout_err} !== 5'b0 ||
            {bus_rr.i_rdata, bus_rr.d_rdata, bus_rr.mem_addr} !== 40'h0) begin
            n_fail++;
            $display("[TB] FAIL midreset_outputs: got %b %h expected 00000 0",
                     {bus_rr.busy, bus_rr.owner, bus_rr.mem_start, bus_rr.mem_rwn, bus_rr.timeout_err},
                     {bus_rr.i_rdata, bus_rr.d_rdata, bus_rr.mem_addr});
        end
        reset = 1'b0;
        do_txn(1'b0, 1'b1, 8'd3, 16'h0, s, a);
        n_checks++;
        if (a !== 7 || bus_rr.i_rdata !== 16'h3C33) begin
            n_fail++;
            $display("[TB] FAIL midreset_refetch: got ack %0d data %h expected 7 3c33", a, bus_rr.i_rdata);
        end
    endtask

    initial begin
        reset = 1'b1;
        hang  = 1'b0;
        bus_rr.i_req = 1'b0; bus_rr.i_addr = '0; bus_rr.d_req = 1'b0;
        bus_rr.d_rwn = 1'b1; bus_rr.d_addr = '0; bus_rr.d_wdata = '0;
        bus_fp.i_req = 1'b0; bus_fp.i_addr = '0; bus_fp.d_req = 1'b0;
        bus_fp.d_rwn = 1'b1; bus_fp.d_addr = '0; bus_fp.d_wdata = '0;
        test_reset();
        test_fetch();
        test_write_read();
        test_round_robin();
        test_fixed_priority();
        test_timeout();
        test_reset_mid_txn();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
